// File: rtl/perceptron_trainer.sv
// Online perceptron trainer: streams in a training set, then runs the perceptron rule
// epoch by epoch until an error-free epoch or the epoch limit. Weights are readable via w_sel.
//   state | meaning
//   IDLE  | waiting for start after reset
//   LOAD  | accepting N_SAMPLES*DIM feature words
//   TRAIN | MAC (DIM cycles) + UPDATE (1 cycle) per sample
//   DONE  | results held until next start
module perceptron_trainer #(
    parameter int DIM        = 2,
    parameter int N_SAMPLES  = 4,
    parameter int DW         = 8,
    parameter int WW         = 16,
    parameter int MAX_EPOCHS = 15,
    parameter int EW         = $clog2(MAX_EPOCHS + 1),
    parameter int SELW       = $clog2(DIM + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_label,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [EW-1:0]        epoch,
    input  logic [SELW-1:0]      w_sel,
    output logic signed [WW-1:0] w_out
);

    localparam int FW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int SW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int PW = DW + WW;
    localparam int AW = PW + $clog2(DIM + 1);
    localparam logic [FW-1:0] F_LAST = FW'(DIM - 1);
    localparam logic [SW-1:0] S_LAST = SW'(N_SAMPLES - 1);
    localparam logic [EW-1:0] E_MAX  = EW'(MAX_EPOCHS);
    localparam logic signed [DW-1:0]   ONE   = DW'(1);
    localparam logic signed [WW+1:0]   W_MAX = {3'b000, {(WW-1){1'b1}}};
    localparam logic signed [WW+1:0]   W_MIN = {3'b111, {(WW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic signed [DW-1:0] x_mem [N_SAMPLES][DIM];
    logic                 label_mem [N_SAMPLES];
    logic signed [WW-1:0] w [DIM];
    logic signed [WW-1:0] bias;
    logic signed [AW-1:0] acc;
    logic [FW-1:0]        ld_f, f_idx;
    logic [SW-1:0]        ld_s, s_idx;
    logic                 upd;
    logic                 err_flag;

    function automatic logic signed [WW-1:0] sat_add(input logic signed [WW-1:0] a,
                                                     input logic signed [DW-1:0] d,
                                                     input logic neg);
        logic signed [WW+1:0] ae, de, s;
        ae = {{2{a[WW-1]}}, a};
        de = {{(WW+2-DW){d[DW-1]}}, d};
        s  = neg ? (ae - de) : (ae + de);
        if (s > W_MAX)      s = W_MAX;
        else if (s < W_MIN) s = W_MIN;
        return s[WW-1:0];
    endfunction

    logic accept_start, xfer, load_last;
    logic signed [PW-1:0] w_ext, x_ext, prod;
    logic signed [AW-1:0] acc_base, acc_sum;
    logic y_hat, e_pos, e_neg, err_now, err_any, last_upd, finish_train;
    logic [EW-1:0] epoch_inc;

    assign accept_start = start && (state == S_IDLE || state == S_DONE);
    assign xfer         = in_valid && in_ready;
    assign load_last    = xfer && (ld_f == F_LAST) && (ld_s == S_LAST);

    assign w_ext    = {{DW{w[f_idx][WW-1]}}, w[f_idx]};
    assign x_ext    = {{WW{x_mem[s_idx][f_idx][DW-1]}}, x_mem[s_idx][f_idx]};
    assign prod     = w_ext * x_ext;
    assign acc_base = (f_idx == '0) ? {{(AW-WW){bias[WW-1]}}, bias} : acc;
    assign acc_sum  = acc_base + {{(AW-PW){prod[PW-1]}}, prod};

    assign y_hat        = !acc[AW-1] && (acc != '0);
    assign e_pos        = label_mem[s_idx] && !y_hat;
    assign e_neg        = !label_mem[s_idx] && y_hat;
    assign err_now      = e_pos || e_neg;
    assign err_any      = err_flag || err_now;
    assign epoch_inc    = epoch + 1'b1;
    assign last_upd     = (state == S_TRAIN) && upd && (s_idx == S_LAST);
    assign finish_train = last_upd && (!err_any || epoch_inc == E_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)        state_nxt = S_LOAD;
            S_LOAD:  if (load_last)    state_nxt = S_TRAIN;
            S_TRAIN: if (finish_train) state_nxt = S_DONE;
            S_DONE:  if (start)        state_nxt = S_LOAD;
            default:                   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_LOAD);
        busy     = (state == S_LOAD) || (state == S_TRAIN);
        done     = (state == S_DONE);
    end

    always_comb begin
        w_out = '0;
        if (w_sel < SELW'(DIM))       w_out = w[w_sel[FW-1:0]];
        else if (w_sel == SELW'(DIM)) w_out = bias;
    end

    // sample storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (xfer) begin
            x_mem[ld_s][ld_f] <= in_data;
            if (ld_f == F_LAST) label_mem[ld_s] <= in_label;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) w[i] <= '0;
            bias      <= '0;
            epoch     <= '0;
            converged <= 1'b0;
            acc       <= '0;
            ld_f      <= '0;
            ld_s      <= '0;
            f_idx     <= '0;
            s_idx     <= '0;
            upd       <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            if (accept_start) begin
                for (int i = 0; i < DIM; i++) w[i] <= '0;
                bias      <= '0;
                epoch     <= '0;
                converged <= 1'b0;
                ld_f      <= '0;
                ld_s      <= '0;
            end
            if (xfer) begin
                if (ld_f == F_LAST) begin
                    ld_f <= '0;
                    ld_s <= ld_s + 1'b1;
                end else begin
                    ld_f <= ld_f + 1'b1;
                end
            end
            if (load_last) begin
                f_idx    <= '0;
                s_idx    <= '0;
                upd      <= 1'b0;
                err_flag <= 1'b0;
            end
            if (state == S_TRAIN) begin
                if (!upd) begin
                    acc <= acc_sum;
                    if (f_idx == F_LAST) upd <= 1'b1;
                    else                 f_idx <= f_idx + 1'b1;
                end else begin
                    upd   <= 1'b0;
                    f_idx <= '0;
                    if (err_now) begin
                        for (int i = 0; i < DIM; i++)
                            w[i] <= sat_add(w[i], x_mem[s_idx][i], e_neg);
                        bias <= sat_add(bias, ONE, e_neg);
                    end
                    if (s_idx == S_LAST) begin
                        s_idx    <= '0;
                        epoch    <= epoch_inc;
                        err_flag <= 1'b0;
                        if (finish_train) converged <= !err_any;
                    end else begin
                        s_idx    <= s_idx + 1'b1;
                        err_flag <= err_any;
                    end
                end
            end
        end
    end

endmodule
